shifter_unit: RTL and testbench

Registered single-bit shifter for the datapath's B operand, ahead of the ALU. It applies one of four shift operations to a WIDTH-bit input and registers the result with a valid flag and status bits. Latency is one clock. The operation encoding matches the instruction shift field.

---
 rtl/shifter_unit.sv | 106 ++++++++++
 tb/tb_shifter_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_unit.sv
`default_nettype none
// ============================================================================
// Module   : shifter_unit
// Purpose  : Registered single-bit shifter for the B operand ahead of the ALU.
//            Applies pass / LSL1 / LSR1 / ASR1 to a WIDTH-bit operand and
//            registers the result with a valid flag and status bits.
//            Latency is one clock, throughput one operation per clock.
// Ports    : clk_i        rising-edge clock
//            rst_ni       synchronous active-low reset
//            in_valid_i   qualifies in_i / shift_i this cycle
//            in_i         operand to shift (WIDTH bits)
//            shift_i      operation select (matches instruction shift field)
//            sout_o       registered shifted result
//            out_valid_o  sout_o / flags hold a new result this cycle
//            shout_o      registered bit shifted out (0 for pass-through)
//            zero_o       registered flag: sout_o == 0
//            neg_o        registered flag: sout_o[WIDTH-1]
// Revision : 1.0 - initial release
// ============================================================================
module shifter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [1:0]       shift_i,
  output logic [WIDTH-1:0] sout_o,
  output logic             out_valid_o,
  output logic             shout_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam logic [1:0] C_OP_PASS = 2'b00;
  localparam logic [1:0] C_OP_LSL  = 2'b01;
  localparam logic [1:0] C_OP_LSR  = 2'b10;
  localparam logic [1:0] C_OP_ASR  = 2'b11;

  logic [WIDTH-1:0] res_d;
  logic             shout_d;

  logic [WIDTH-1:0] sout_q;
  logic             valid_q;
  logic             shout_q;
  logic             zero_q;
  logic             neg_q;

  // Shift decode; the default arm keeps the case full so no latch appears
  // even when shift_i carries unknowns.
  always_comb begin
    res_d   = in_i;
    shout_d = 1'b0;
    case (shift_i)
      C_OP_PASS: begin
        res_d   = in_i;
        shout_d = 1'b0;
      end
      C_OP_LSL: begin
        res_d   = {in_i[WIDTH-2:0], 1'b0};
        shout_d = in_i[WIDTH-1];
      end
      C_OP_LSR: begin
        res_d   = {1'b0, in_i[WIDTH-1:1]};
        shout_d = in_i[0];
      end
      C_OP_ASR: begin
        res_d   = {in_i[WIDTH-1], in_i[WIDTH-1:1]};
        shout_d = in_i[0];
      end
      default: begin
        res_d   = in_i;
        shout_d = 1'b0;
      end
    endcase
  end

  // Reset takes priority over an accepted operation in the same cycle, so a
  // result presented alongside reset is dropped. Without in_valid_i the data
  // and flags hold and only the valid flag drops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sout_q  <= '0;
      valid_q <= 1'b0;
      shout_q <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else if (in_valid_i) begin
      sout_q  <= res_d;
      valid_q <= 1'b1;
      shout_q <= shout_d;
      zero_q  <= (res_d == '0);
      neg_q   <= res_d[WIDTH-1];
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign sout_o      = sout_q;
  assign out_valid_o = valid_q;
  assign shout_o     = shout_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_shifter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_unit
// Purpose  : Directed self-checking bench for shifter_unit (WIDTH = 16).
//            Inputs are driven 1 time unit after a rising edge and outputs
//            are sampled 1 time unit after the following rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shifter_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] din;
  logic [1:0]  shift;
  logic [15:0] sout;
  logic        out_valid;
  logic        shout;
  logic        zero;
  logic        neg;

  int n_checks = 0;
  int n_fail   = 0;

  shifter_unit #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_i        (din),
    .shift_i     (shift),
    .sout_o      (sout),
    .out_valid_o (out_valid),
    .shout_o     (shout),
    .zero_o      (zero),
    .neg_o       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    din      = 16'hFFFF;
    shift    = 2'b01;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (sout !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_sout cyc%0d: got %h want 0000", c, sout);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid cyc%0d: got %b want 0", c, out_valid);
      end
      n_checks++;
      if (zero !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_zero cyc%0d: got %b want 1", c, zero);
      end
      n_checks++;
      if (neg !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_neg cyc%0d: got %b want 0", c, neg);
      end
      n_checks++;
      if (shout !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_shout cyc%0d: got %b want 0", c, shout);
      end
    end
  endtask

  // Four shift codes back-to-back on one operand; expected values per code.
  task automatic test_ops(input logic [15:0] op, input logic [15:0] e_sout [4],
                          input logic e_shout [4], input logic e_neg [4]);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    din      = op;
    for (int k = 0; k < 4; k++) begin
      shift = 2'(k);
      tick();
      n_checks++;
      if (sout !== e_sout[k]) begin
        n_fail++;
        $display("FAIL ops_sout in=%h sh=%0d: got %h want %h", op, k, sout, e_sout[k]);
      end
      n_checks++;
      if (shout !== e_shout[k]) begin
        n_fail++;
        $display("FAIL ops_shout in=%h sh=%0d: got %b want %b", op, k, shout, e_shout[k]);
      end
      n_checks++;
      if (neg !== e_neg[k]) begin
        n_fail++;
        $display("FAIL ops_neg in=%h sh=%0d: got %b want %b", op, k, neg, e_neg[k]);
      end
      n_checks++;
      if (zero !== 1'b0) begin
        n_fail++;
        $display("FAIL ops_zero in=%h sh=%0d: got %b want 0", op, k, zero);
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ops_valid in=%h sh=%0d: got %b want 1", op, k, out_valid);
      end
    end
  endtask

  // Entered directly after 0xF0CF / ASR, so the registered result is 0xF867.
  task automatic test_hold();
    in_valid = 1'b0;
    din      = 16'h1234;
    shift    = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (sout !== 16'hF867) begin
        n_fail++;
        $display("FAIL hold_sout cyc%0d: got %h want f867", c, sout);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_valid cyc%0d: got %b want 0", c, out_valid);
      end
      n_checks++;
      if (shout !== 1'b1 || neg !== 1'b1 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_flags cyc%0d: got shout=%b neg=%b zero=%b want 1 1 0",
                 c, shout, neg, zero);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] v_in    [4] = '{16'h8000, 16'h0001, 16'h8001, 16'hFFFF};
    logic [1:0]  v_sh    [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [15:0] v_sout  [4] = '{16'h0000, 16'h0000, 16'hC000, 16'hFFFF};
    logic        v_zero  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        v_neg   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    rst_n    = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din   = v_in[k];
      shift = v_sh[k];
      tick();
      n_checks++;
      if (sout !== v_sout[k]) begin
        n_fail++;
        $display("FAIL bnd_sout in=%h: got %h want %h", v_in[k], sout, v_sout[k]);
      end
      n_checks++;
      if (zero !== v_zero[k]) begin
        n_fail++;
        $display("FAIL bnd_zero in=%h: got %b want %b", v_in[k], zero, v_zero[k]);
      end
      n_checks++;
      if (neg !== v_neg[k]) begin
        n_fail++;
        $display("FAIL bnd_neg in=%h: got %b want %b", v_in[k], neg, v_neg[k]);
      end
      n_checks++;
      if (shout !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bnd_shout_valid in=%h: got shout=%b valid=%b want 1 1",
                 v_in[k], shout, out_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    din      = 16'h0F0F;
    shift    = 2'b00;
    tick();
    n_checks++;
    if (sout !== 16'h0F0F || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got sout=%h valid=%b want 0f0f 1", sout, out_valid);
    end
    // Operation presented together with reset must be discarded.
    rst_n = 1'b0;
    din   = 16'h1234;
    shift = 2'b01;
    tick();
    n_checks++;
    if (sout !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got sout=%h valid=%b want 0000 0", sout, out_valid);
    end
    n_checks++;
    if (zero !== 1'b1 || shout !== 1'b0 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_flags: got zero=%b shout=%b neg=%b want 1 0 0",
               zero, shout, neg);
    end
    rst_n = 1'b1;
    din   = 16'h00F0;
    shift = 2'b01;
    tick();
    n_checks++;
    if (sout !== 16'h01E0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_resume1: got sout=%h valid=%b want 01e0 1", sout, out_valid);
    end
    shift = 2'b10;
    tick();
    n_checks++;
    if (sout !== 16'h0078 || out_valid !== 1'b1 || shout !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_resume2: got sout=%h valid=%b shout=%b want 0078 1 0",
               sout, out_valid, shout);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    shift    = '0;
    #1;
    test_reset();
    test_ops(16'h70CF, '{16'h70CF, 16'hE19E, 16'h3867, 16'h3867},
             '{1'b0, 1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0, 1'b0});
    test_ops(16'hF0CF, '{16'hF0CF, 16'hE19E, 16'h7867, 16'hF867},
             '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1});
    test_hold();
    test_boundaries();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
